tm_infer_seq: RTL and testbench

- Parametrised, time-multiplexed Tsetlin-machine inference engine for N_FEAT features, N_CLASS classes and N_CLAUSE clauses per class.
- Holds per-clause exclude masks in an internal register file, loaded through a config write port.
- Evaluates one clause per clock, accumulates signed polarity votes per class, then runs a sequential argmax.
- Results are returned over a valid/ready handshake; it is the successor to the fixed 2-feature/2-class/4-clause combinational inference block.

---
 rtl/tm_infer_seq.sv | 130 +++++++++++++
 tb/tb_tm_infer_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tm_infer_seq.sv
// Time-multiplexed Tsetlin-machine inference: one clause per cycle into signed
// per-class vote sums, then a sequential argmax, with the result held under valid/ready.
module tm_infer_seq #(
    parameter  int N_FEAT   = 2,
    parameter  int N_CLASS  = 2,
    parameter  int N_CLAUSE = 4,
    localparam int SUM_W    = $clog2(N_CLAUSE) + 1,
    localparam int CLS_W    = $clog2(N_CLASS),
    localparam int ADDR_W   = $clog2(N_CLASS * N_CLAUSE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [2*N_FEAT-1:0]     cfg_mask,
    output logic                    cfg_ready,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_FEAT-1:0]       features,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CLS_W-1:0]        out_class,
    output logic signed [SUM_W-1:0] out_score,
    output logic                    busy
);
    localparam int N_TOTAL = N_CLASS * N_CLAUSE;
    localparam int M_W     = 2 * N_FEAT;

    typedef enum logic [1:0] {IDLE, EVAL, CMP, DONE} state_t;

    state_t                   state_q;
    logic [M_W-1:0]           mask_q [N_TOTAL];
    logic [N_FEAT-1:0]        feat_q;
    logic [ADDR_W-1:0]        cnt_q;
    logic [CLS_W-1:0]         cmp_idx_q;
    logic signed [SUM_W-1:0]  sum_q [N_CLASS];
    logic signed [SUM_W-1:0]  best_q;
    logic [CLS_W-1:0]         best_idx_q;
    logic                     out_valid_q;
    logic [CLS_W-1:0]         out_class_q;
    logic signed [SUM_W-1:0]  out_score_q;

    logic [M_W-1:0]           lits;
    logic [M_W-1:0]           cur_mask;
    logic                     clause_hit;
    logic [CLS_W-1:0]         cls_idx;
    logic signed [SUM_W-1:0]  vote;
    logic signed [SUM_W-1:0]  cand;
    logic                     take;
    logic signed [SUM_W-1:0]  best_d;
    logic [CLS_W-1:0]         best_idx_d;

    always_comb begin
        lits       = {~feat_q, feat_q};
        cur_mask   = mask_q[cnt_q];
        // An all-excluded clause must vote 0, not the vacuous AND of 1.
        clause_hit = (cur_mask != '1) && (&(lits | cur_mask));
        cls_idx    = CLS_W'(cnt_q / ADDR_W'(N_CLAUSE));
        // N_CLAUSE is even, so global index parity equals in-class parity.
        vote       = cnt_q[0] ? '1 : SUM_W'(1);
        cand       = sum_q[cmp_idx_q];
        take       = (cmp_idx_q == '0) || (cand > best_q);
        best_d     = take ? cand : best_q;
        best_idx_d = take ? cmp_idx_q : best_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < N_TOTAL; i++) mask_q[i] <= '1;
            for (int c = 0; c < N_CLASS; c++) sum_q[c] <= '0;
            feat_q      <= '0;
            cnt_q       <= '0;
            cmp_idx_q   <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
        end else begin
            if (cfg_we && state_q == IDLE && int'(cfg_addr) < N_TOTAL)
                mask_q[cfg_addr] <= cfg_mask;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        feat_q  <= features;
                        for (int c = 0; c < N_CLASS; c++) sum_q[c] <= '0;
                        cnt_q   <= '0;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (clause_hit) sum_q[cls_idx] <= sum_q[cls_idx] + vote;
                    if (cnt_q == ADDR_W'(N_TOTAL - 1)) begin
                        cmp_idx_q <= '0;
                        state_q   <= CMP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CMP: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    if (cmp_idx_q == CLS_W'(N_CLASS - 1)) begin
                        out_class_q <= best_idx_d;
                        out_score_q <= best_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cmp_idx_q <= cmp_idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;
endmodule

// File: tb/tb_tm_infer_seq.sv
// Directed and randomized bench for tm_infer_seq with a plain-arithmetic class-vote model.
module tb_tm_infer_seq;
    localparam int NF = 2, NC = 2, NCL = 4, NT = NC * NCL, LAT = NT + NC;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [3:0]        cfg_mask;
    logic              cfg_ready;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        features;
    logic              out_valid;
    logic              out_ready;
    logic [0:0]        out_class;
    logic signed [2:0] out_score;
    logic              busy;

    int errors = 0;
    int checks = 0;
    logic [3:0] mdl [NT];

    tm_infer_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .features(features),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_score(out_score), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: literal i is f[i], literal NF+i is !f[i]; clause fires when every
    // included literal is true and at least one is included; even clause +1, odd -1.
    function automatic void predict(input logic [1:0] f, output int cls, output int sc);
        int sums [NC];
        bit lit [4];
        for (int i = 0; i < NF; i++) begin
            lit[i]      = f[i];
            lit[NF + i] = !f[i];
        end
        for (int c = 0; c < NC; c++) begin
            sums[c] = 0;
            for (int j = 0; j < NCL; j++) begin
                bit fire = 1'b1;
                int incl = 0;
                for (int b = 0; b < 2 * NF; b++) begin
                    if (mdl[c * NCL + j][b] == 1'b0) begin
                        incl++;
                        if (!lit[b]) fire = 1'b0;
                    end
                end
                if (incl > 0 && fire) sums[c] += (j % 2 == 0) ? 1 : -1;
            end
        end
        cls = 0;
        sc  = sums[0];
        for (int c = 1; c < NC; c++)
            if (sums[c] > sc) begin
                cls = c;
                sc  = sums[c];
            end
    endfunction

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] m);
        cfg_we = 1'b1; cfg_addr = a; cfg_mask = m;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mdl[a] = m;
    endtask

    task automatic run_inf(input string tag, input logic [1:0] f, input int hold, input bit poke);
        int ecls, esc, lat;
        predict(f, ecls, esc);
        features = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".busy_eval"}, busy, 1);
        check({tag, ".in_ready_eval"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".class"}, out_class, ecls);
        check({tag, ".score"}, out_score, esc);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 0) begin
                cfg_we = 1'b1; cfg_addr = 3'd4; cfg_mask = 4'b1110;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_class"}, out_class, ecls);
            check({tag, ".hold_score"}, out_score, esc);
            check({tag, ".hold_in_ready"}, in_ready, 0);
            check({tag, ".hold_cfg_ready"}, cfg_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".post_valid"}, out_valid, 0);
        check({tag, ".post_in_ready"}, in_ready, 1);
        check({tag, ".post_busy"}, busy, 0);
        check({tag, ".post_class"}, out_class, ecls);
        check({tag, ".post_score"}, out_score, esc);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0;
        in_valid = 1'b0; features = '0; out_ready = 1'b0;
        for (int i = 0; i < NT; i++) mdl[i] = 4'hF;
        #12;
        check("rst.out_valid", out_valid, 0);
        check("rst.out_class", out_class, 0);
        check("rst.out_score", out_score, 0);
        check("rst.busy", busy, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.cfg_ready", cfg_ready, 1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_inf("noconf", 2'b01, 0, 1'b0);
        check("noconf.model", 0, 0 + out_class);

        cfg_write(3'd4, 4'b1110);
        run_inf("c1f0", 2'b01, 0, 1'b0);
        check("c1f0.win_is_1", out_class, 1);
        run_inf("c1f1", 2'b10, 1, 1'b0);

        cfg_write(3'd0, 4'b1110);
        run_inf("tie", 2'b01, 0, 1'b0);
        check("tie.score_pos", out_score, 1);

        cfg_write(3'd0, 4'b1111);
        cfg_write(3'd4, 4'b1111);
        cfg_write(3'd1, 4'b1110);
        run_inf("neg", 2'b01, 0, 1'b0);
        check("neg.win_is_1", out_class, 1);
        cfg_write(3'd0, 4'b0000);
        run_inf("contra", 2'b01, 0, 1'b0);

        run_inf("holddrop", 2'b01, 5, 1'b1);
        run_inf("holdrepeat", 2'b01, 0, 1'b0);
        check("holdrepeat.score", out_score, 0);

        features = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort.out_valid", out_valid, 0);
        check("abort.busy", busy, 0);
        check("abort.in_ready", in_ready, 1);
        check("abort.out_score", out_score, 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < NT; i++) mdl[i] = 4'hF;
        @(posedge clk); #1;
        run_inf("after_abort", 2'b01, 0, 1'b0);

        for (int it = 0; it < 16; it++) begin
            int nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                cfg_write(3'($urandom_range(0, NT - 1)), 4'($urandom));
            run_inf($sformatf("rnd%0d", it), 2'($urandom), $urandom_range(0, 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
